// File: rtl/frv_mdu_arbiter_pkg.sv
// Shared core constants for the MDU arbiter: 3-bit MDU op encodings and the
// arbiter FSM state encodings.
package frv_mdu_arbiter_pkg;

    // MDU op codes as presented on r0_op / r1_op / m_op.
    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHU  = 3'd2,
        MDU_MULHSU = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    // Arbiter ownership states.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN0  = 2'd1,
        ARB_OWN1  = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/frv_mdu_arbiter.sv
// frv_mdu_arbiter: shares one multiply/divide unit between the execute stage
// (r0) and an auxiliary requester (r1). Ties in IDLE go round-robin via the
// 'last' register. After every completion the MDU is flushed for one DRAIN
// cycle before it can be granted again.
//
// Ports:
//   g_clk, g_reset           clock, synchronous active-high reset
//   rX_valid/op/rs1/rs2      requester X command (held until ready or dropped)
//   rX_flush                 requester X abort
//   rX_ready                 one-cycle completion pulse to requester X
//   rd                       result, meaningful only alongside a ready pulse
//   m_valid/op/rs1/rs2       command to the shared MDU (operands not registered)
//   m_flush                  clears the MDU (reset, abort, drain)
//   m_ready, m_rd            MDU completion and result
//   busy                     arbiter not IDLE
module frv_mdu_arbiter
    import frv_mdu_arbiter_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int XL  = XLEN - 1
) (
    input  logic          g_clk,
    input  logic          g_reset,

    input  logic          r0_valid,
    input  logic [2:0]    r0_op,
    input  logic [XL:0]   r0_rs1,
    input  logic [XL:0]   r0_rs2,
    input  logic          r0_flush,
    output logic          r0_ready,

    input  logic          r1_valid,
    input  logic [2:0]    r1_op,
    input  logic [XL:0]   r1_rs1,
    input  logic [XL:0]   r1_rs2,
    input  logic          r1_flush,
    output logic          r1_ready,

    output logic [XL:0]   rd,

    output logic          m_valid,
    output logic [2:0]    m_op,
    output logic [XL:0]   m_rs1,
    output logic [XL:0]   m_rs2,
    output logic          m_flush,
    input  logic          m_ready,
    input  logic [XL:0]   m_rd,

    output logic          busy
);

    arb_state_t state;
    logic       last;       // id of the most recently granted requester

    logic own0, own1, drain;
    logic req0, req1, grant0, grant1;
    logic cur_valid, cur_flush, abort;

    // Ownership decodes are masked by reset so nothing leaks out while the
    // state register is being forced back to IDLE.
    assign own0  = !g_reset && (state == ARB_OWN0);
    assign own1  = !g_reset && (state == ARB_OWN1);
    assign drain = !g_reset && (state == ARB_DRAIN);

    // A requester that is flushing is not a candidate for grant.
    assign req0   = r0_valid && !r0_flush;
    assign req1   = r1_valid && !r1_flush;
    assign grant0 = req0 && (!req1 || last);
    assign grant1 = req1 && (!req0 || !last);

    assign cur_valid = own0 ? r0_valid : r1_valid;
    assign cur_flush = own0 ? r0_flush : r1_flush;

    // Owner abort: explicit flush always wins the state decision, even when
    // m_ready arrives in the same cycle. A dropped valid only counts as an
    // abort if the MDU is not completing right now.
    assign abort = (own0 || own1) && (cur_flush || (!cur_valid && !m_ready));

    assign m_valid = own0 ? r0_valid : (own1 ? r1_valid : 1'b0);
    assign m_op    = own0 ? r0_op    : (own1 ? r1_op    : 3'd0);
    assign m_rs1   = own0 ? r0_rs1   : (own1 ? r1_rs1   : '0);
    assign m_rs2   = own0 ? r0_rs2   : (own1 ? r1_rs2   : '0);
    assign m_flush = g_reset || drain || abort;

    assign r0_ready = own0 && m_ready;
    assign r1_ready = own1 && m_ready;
    assign rd       = m_rd;
    assign busy     = !g_reset && (state != ARB_IDLE);

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state <= ARB_IDLE;
            last  <= 1'b1;          // r0 wins the first tie
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant0) begin
                        state <= ARB_OWN0;
                        last  <= 1'b0;
                    end else if (grant1) begin
                        state <= ARB_OWN1;
                        last  <= 1'b1;
                    end
                end
                ARB_OWN0, ARB_OWN1: begin
                    if (abort)
                        state <= ARB_IDLE;
                    else if (m_ready)
                        state <= ARB_DRAIN;
                end
                ARB_DRAIN: state <= ARB_IDLE;
                default:   state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frv_mdu_arbiter.sv
// Scoreboard bench for frv_mdu_arbiter. Stimulus pushes the expected
// completion (requester id + result) in the order it must appear; a monitor
// pops and compares on every ready pulse. A small behavioural MDU answers
// m_valid after a programmable latency with a result computed from m_op/m_rs*.
module tb_frv_mdu_arbiter;
    import frv_mdu_arbiter_pkg::*;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        r0_valid = 0, r1_valid = 0, r0_flush = 0, r1_flush = 0;
    logic [2:0]  r0_op = 0, r1_op = 0;
    logic [31:0] r0_rs1 = 0, r0_rs2 = 0, r1_rs1 = 0, r1_rs2 = 0;
    logic        r0_ready, r1_ready;
    logic [31:0] rd;
    logic        m_valid, m_flush, busy;
    logic        m_ready = 1'b0;
    logic [2:0]  m_op;
    logic [31:0] m_rs1, m_rs2, m_rd;

    frv_mdu_arbiter #(.XLEN(32)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .r0_valid(r0_valid), .r0_op(r0_op), .r0_rs1(r0_rs1), .r0_rs2(r0_rs2),
        .r0_flush(r0_flush), .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_op(r1_op), .r1_rs1(r1_rs1), .r1_rs2(r1_rs2),
        .r1_flush(r1_flush), .r1_ready(r1_ready),
        .rd(rd),
        .m_valid(m_valid), .m_op(m_op), .m_rs1(m_rs1), .m_rs2(m_rs2),
        .m_flush(m_flush), .m_ready(m_ready), .m_rd(m_rd),
        .busy(busy)
    );

    always #5 g_clk = ~g_clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { bit who; logic [31:0] val; } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input bit who, input logic [31:0] val);
        exp_t e;
        e.who = who;
        e.val = val;
        sb_q.push_back(e);
    endtask

    // Behavioural MDU.
    function automatic logic [31:0] mdu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd3: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFFFFFF : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: return (b == 0) ? a : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    assign m_rd = mdu_ref(m_op, m_rs1, m_rs2);

    int mdu_lat = 2;
    int mdu_cnt = 0;
    always @(posedge g_clk) begin
        logic sv, sf, sr;
        sv = m_valid;
        sf = m_flush;
        sr = m_ready;
        #1;
        if (sv && !sf && !sr) begin
            mdu_cnt++;
            if (mdu_cnt >= mdu_lat) begin
                m_ready = 1'b1;
                mdu_cnt = 0;
            end
        end else begin
            m_ready = 1'b0;
            mdu_cnt = 0;
        end
    end

    // Monitor: every ready pulse must match the head of the scoreboard.
    always @(negedge g_clk) begin
        exp_t e;
        if (r0_ready && r1_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dual_ready: got both ready want one");
        end else if (r0_ready || r1_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: got r%0d_ready rd=%h want none", r1_ready, rd);
            end else begin
                e = sb_q.pop_front();
                chk("ready_owner", {31'd0, r1_ready}, {31'd0, e.who});
                chk("ready_rd", rd, e.val);
            end
        end
    end

    task automatic wait_rdy(input bit who, input string nm);
        bit ok;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge g_clk);
            if (who ? r1_ready : r0_ready) begin
                ok = 1;
                break;
            end
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    // Issue one request from requester 'who' and hold it until ready.
    // Entered and left at 1 time unit after a rising edge.
    task automatic drive(input bit who, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        if (who) begin
            r1_valid = 1; r1_flush = 0; r1_op = op; r1_rs1 = a; r1_rs2 = b;
        end else begin
            r0_valid = 1; r0_flush = 0; r0_op = op; r0_rs1 = a; r0_rs2 = b;
        end
        wait_rdy(who, who ? "r1_done" : "r0_done");
        @(posedge g_clk); #1;
        if (who) r1_valid = 0; else r0_valid = 0;
    endtask

    task automatic do_reset();
        g_reset = 1;
        @(negedge g_clk);
        chk("rst_m_flush", {31'd0, m_flush}, 32'd1);
        chk("rst_quiet", {28'd0, m_valid, busy, r0_ready, r1_ready}, 32'd0);
        @(posedge g_clk); #1;
        g_reset = 0;
        @(negedge g_clk);
        chk("post_rst_idle", {30'd0, m_flush, busy}, 32'd0);
        @(posedge g_clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge g_clk);
        #1;
        do_reset();

        // Single MUL on r0, with a harmless non-owner flush from r1.
        push(0, 32'd42);
        r0_valid = 1; r0_op = MDU_MUL; r0_rs1 = 6; r0_rs2 = 7; r1_flush = 1;
        @(negedge g_clk);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        @(negedge g_clk);
        chk("t1_own0", {29'd0, busy, m_valid, m_flush}, 32'b110);
        chk("t1_m_op", {29'd0, m_op}, 32'd0);
        chk("t1_m_rs2", m_rs2, 32'd7);
        wait_rdy(0, "t1_ready");
        @(posedge g_clk); #1;
        r0_valid = 0; r1_flush = 0;
        @(negedge g_clk);
        chk("t1_drain", {30'd0, busy, m_flush}, 32'b11);
        @(negedge g_clk);
        chk("t1_back_idle", {30'd0, busy, m_flush}, 32'b00);
        @(posedge g_clk); #1;

        // A flushing requester is not granted from IDLE.
        do_reset();
        push(1, 32'd14);
        r1_valid = 1; r1_flush = 1; r1_op = MDU_DIVU; r1_rs1 = 100; r1_rs2 = 7;
        @(negedge g_clk);
        @(negedge g_clk);
        chk("t2_no_grant", {31'd0, busy}, 32'd0);
        @(posedge g_clk); #1;
        drive(1, MDU_DIVU, 32'd100, 32'd7);

        // Tie from reset goes to r0, then r1, then r0 re-request.
        do_reset();
        push(0, 32'd42);
        push(1, 32'd14);
        push(0, 32'hFFFFFFFE);
        fork
            begin
                drive(0, MDU_MUL, 32'd6, 32'd7);
                drive(0, MDU_REM, 32'hFFFFFFEC, 32'd3);
            end
            drive(1, MDU_DIVU, 32'd100, 32'd7);
        join

        // Owner flush mid-divide, then owner abandons a request.
        do_reset();
        mdu_lat = 20;
        r1_valid = 1; r1_op = MDU_DIV; r1_rs1 = 32'hFFFFFFEC; r1_rs2 = 3;
        @(negedge g_clk);
        @(negedge g_clk);
        chk("t4_own1", {31'd0, busy}, 32'd1);
        chk("t4_m_op", {29'd0, m_op}, 32'd4);
        @(posedge g_clk); #1;
        @(posedge g_clk); #1;
        r1_flush = 1;
        @(negedge g_clk);
        chk("t4_flush_now", {31'd0, m_flush}, 32'd1);
        @(posedge g_clk); #1;
        r1_flush = 0; r1_valid = 0;
        @(negedge g_clk);
        chk("t4_idle", {30'd0, busy, m_flush}, 32'b00);
        @(posedge g_clk); #1;
        r0_valid = 1; r0_op = MDU_MULHU; r0_rs1 = 32'hFFFFFFFF; r0_rs2 = 2;
        @(negedge g_clk);
        @(negedge g_clk);
        chk("t4b_own0", {31'd0, busy}, 32'd1);
        @(posedge g_clk); #1;
        r0_valid = 0;
        @(negedge g_clk);
        chk("t4b_abandon_flush", {31'd0, m_flush}, 32'd1);
        @(negedge g_clk);
        chk("t4b_idle", {31'd0, busy}, 32'd0);
        @(posedge g_clk); #1;

        // m_ready coincident with owner flush: ready still pulses, no DRAIN.
        do_reset();
        mdu_lat = 3;
        push(0, 32'd15);
        r0_valid = 1; r0_op = MDU_MUL; r0_rs1 = 3; r0_rs2 = 5;
        begin
            bit seen;
            seen = 0;
            for (int t = 0; t < 50; t++) begin
                @(posedge g_clk); #2;
                if (m_ready) begin
                    seen = 1;
                    break;
                end
            end
            chk("t5_m_ready_seen", {31'd0, seen}, 32'd1);
        end
        r0_flush = 1;
        @(negedge g_clk);
        chk("t5_flush_with_ready", {30'd0, m_flush, r0_ready}, 32'b11);
        @(posedge g_clk); #1;
        r0_flush = 0; r0_valid = 0;
        @(negedge g_clk);
        chk("t5_idle_not_drain", {31'd0, busy}, 32'd0);
        @(posedge g_clk); #1;

        // Reset during OWN0: no ready, IDLE after, r0 still wins next tie.
        mdu_lat = 10;
        r0_valid = 1; r0_op = MDU_MUL; r0_rs1 = 6; r0_rs2 = 7;
        @(negedge g_clk);
        @(negedge g_clk);
        chk("t6_own0", {31'd0, busy}, 32'd1);
        @(posedge g_clk); #1;
        g_reset = 1;
        @(negedge g_clk);
        chk("t6_rst_outputs", {29'd0, m_flush, busy, r0_ready}, 32'b100);
        @(posedge g_clk); #1;
        g_reset = 0; r0_valid = 0;
        @(negedge g_clk);
        chk("t6_idle", {31'd0, busy}, 32'd0);
        @(posedge g_clk); #1;
        mdu_lat = 2;
        push(0, 32'd42);
        push(1, 32'd1);
        fork
            drive(0, MDU_MUL, 32'd6, 32'd7);
            drive(1, MDU_MULHU, 32'hFFFFFFFF, 32'd2);
        join

        // r1 continuously valid while r0 issues back-to-back: strict alternation.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(0, 32'((i + 1) * 10));
            push(1, 32'((i + 1) * 3));
        end
        fork
            for (int i = 0; i < 5; i++) drive(0, MDU_MUL, 32'(i + 1), 32'd10);
            for (int j = 0; j < 5; j++) drive(1, MDU_DIVU, 32'((j + 1) * 21), 32'd7);
        join

        // Signed high-word ops through r1.
        push(1, 32'hFFFFFFFF);
        push(1, 32'hFFFFFFFF);
        push(0, 32'hFFFFFFFA);
        drive(1, MDU_MULH, 32'hFFFFFFFE, 32'd3);
        drive(1, MDU_MULHSU, 32'hFFFFFFFF, 32'd2);
        drive(0, MDU_DIV, 32'hFFFFFFEC, 32'd3);

        repeat (3) @(negedge g_clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
